// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register and its wrappers.
package pipe_pkg;

    localparam int WORD_W       = 32;
    localparam int MEMWB_DATA_W = 5 * WORD_W;

    // Occupancy-coded states: the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Upstream/downstream handshake bundle for one elastic stage.
// master = surrounding stages (producer and consumer), slave = the stage itself.
interface pipe_stage_elastic_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CTRL_W = 1
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

endinterface

// File: rtl/pipe_stage_elastic.sv
// Generic handshaked pipeline register with flush and optional 2-entry skid.
// DATA_W/CTRL_W must match the parameters of the connected interface.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | main entry valid
// ST_TWO   | main and skid entries valid, in_ready=0 (skid only)
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CTRL_W = 1,
    parameter int SKID   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  bus
);

    // Anything other than 0 selects the skid-buffer variant.
    localparam bit SKID_EN = (SKID != 0);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic in_ready;
    logic in_fire;
    logic out_fire;

    // Skid mode breaks the ready path; single-entry mode passes out_ready through.
    assign in_ready = SKID_EN ? in_ready_q : (!out_valid_q || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_ctrl  = main_ctrl_q;
    assign bus.occupancy = state_q;

    // Next-state and entry updates; emptied entries get ctrl cleared so bubbles carry ctrl=0.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_data_d = bus.in_data;
                    main_ctrl_d = bus.in_ctrl;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = bus.in_data;
                    main_ctrl_d = bus.in_ctrl;
                end else if (in_fire && SKID_EN) begin
                    skid_data_d = bus.in_data;
                    skid_ctrl_d = bus.in_ctrl;
                    state_d     = ST_TWO;
                end else if (out_fire) begin
                    main_ctrl_d = '0;
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_ctrl_d = '0;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
                state_d     = ST_EMPTY;
            end
        endcase

        // Flush drops everything including a same-cycle input; payload is left stale.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // State and entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one single-entry and one skid instance side by side.
module tb_pipe_stage_elastic;

    localparam int DW = 160;
    localparam int CW = 1;

    typedef logic [DW+CW-1:0] ent_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t sb0[$];
    ent_t sb1[$];

    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();
    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus0)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: outputs popped first, then flush drops the queue, else accepted beats pushed.
    always @(negedge clk) begin
        if (reset) begin
            sb0.delete();
            sb1.delete();
        end else begin
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb0.size() == 0) check_eq("sb0_unexpected_out", {bus0.out_ctrl, bus0.out_data}, '1);
                else check_eq("sb0_order", {bus0.out_ctrl, bus0.out_data}, sb0.pop_front());
            end
            if (bus1.out_valid && bus1.out_ready) begin
                if (sb1.size() == 0) check_eq("sb1_unexpected_out", {bus1.out_ctrl, bus1.out_data}, '1);
                else check_eq("sb1_order", {bus1.out_ctrl, bus1.out_data}, sb1.pop_front());
            end
            if (flush) begin
                sb0.delete();
                sb1.delete();
            end else begin
                if (bus0.in_valid && bus0.in_ready) sb0.push_back({bus0.in_ctrl, bus0.in_data});
                if (bus1.in_valid && bus1.in_ready) sb1.push_back({bus1.in_ctrl, bus1.in_data});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_ctrl = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_ctrl = '0;
    endtask

    task automatic check_reset_state();
        check_eq("rst_ov0",  bus0.out_valid, 0);
        check_eq("rst_od0",  bus0.out_data,  0);
        check_eq("rst_oc0",  bus0.out_ctrl,  0);
        check_eq("rst_occ0", bus0.occupancy, 0);
        check_eq("rst_ov1",  bus1.out_valid, 0);
        check_eq("rst_od1",  bus1.out_data,  0);
        check_eq("rst_oc1",  bus1.out_ctrl,  0);
        check_eq("rst_occ1", bus1.occupancy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        bus0.in_valid = 1'b1; bus0.in_data = 160'h55; bus0.in_ctrl = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_data = 160'h66; bus1.in_ctrl = 1'b1;

        // Reset for two cycles with traffic offered
        step(2);
        check_reset_state();
        reset = 1'b0;
        idle_inputs();
        #1;
        check_eq("rst_ir0", bus0.in_ready, 1);
        check_eq("rst_ir1", bus1.in_ready, 1);
        step(1);

        // Streaming 8 beats into both variants
        for (int i = 1; i <= 8; i++) begin
            bus0.in_valid = 1'b1; bus0.in_data = 160'(i); bus0.in_ctrl = 1'b1;
            bus1.in_valid = 1'b1; bus1.in_data = 160'(i); bus1.in_ctrl = 1'b1;
            #1;
            check_eq("stream_ir0", bus0.in_ready, 1);
            check_eq("stream_ir1", bus1.in_ready, 1);
            step(1);
            check_eq("stream_ov0", bus0.out_valid, 1);
            check_eq("stream_ov1", bus1.out_valid, 1);
        end
        idle_inputs();
        step(3);
        check_eq("stream_drain_ov0", bus0.out_valid, 0);
        check_eq("stream_drain_ov1", bus1.out_valid, 0);
        check_eq("stream_drain_oc1", bus1.out_ctrl, 0);
        check_eq("stream_sb0", sb0.size(), 0);
        check_eq("stream_sb1", sb1.size(), 0);

        // Skid backpressure: A, B fill both entries, C waits upstream
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 160'hA; bus1.in_ctrl = 1'b1;
        step(1);
        check_eq("bp1_occ_a", bus1.occupancy, 1);
        check_eq("bp1_ir_a",  bus1.in_ready, 1);
        bus1.in_data = 160'hB;
        step(1);
        check_eq("bp1_occ_b", bus1.occupancy, 2);
        check_eq("bp1_ir_b",  bus1.in_ready, 0);
        check_eq("bp1_head",  bus1.out_data, 160'hA);
        bus1.in_data = 160'hC;
        step(2);
        check_eq("bp1_occ_hold", bus1.occupancy, 2);
        check_eq("bp1_sb_hold",  sb1.size(), 2);
        bus1.out_ready = 1'b1;
        step(1);
        check_eq("bp1_occ_rel", bus1.occupancy, 1);
        check_eq("bp1_ir_rel",  bus1.in_ready, 1);
        step(1);
        idle_inputs();
        step(3);
        check_eq("bp1_drain_ov", bus1.out_valid, 0);
        check_eq("bp1_drain_sb", sb1.size(), 0);

        // Single-entry backpressure: in_ready follows out_ready combinationally
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 160'h11; bus0.in_ctrl = 1'b1;
        step(1);
        check_eq("bp0_ov", bus0.out_valid, 1);
        bus0.in_data = 160'h12; bus0.in_ctrl = 1'b0;
        #1;
        check_eq("bp0_ir_low", bus0.in_ready, 0);
        bus0.out_ready = 1'b1;
        #1;
        check_eq("bp0_ir_high", bus0.in_ready, 1);
        step(1);
        check_eq("bp0_next", bus0.out_data, 160'h12);
        check_eq("bp0_next_ctrl", bus0.out_ctrl, 0);
        idle_inputs();
        step(2);
        check_eq("bp0_drain_ov", bus0.out_valid, 0);
        check_eq("bp0_drain_sb", sb0.size(), 0);

        // Flush in TWO with input offered on both instances
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 160'h21; bus1.in_ctrl = 1'b1;
        step(1);
        bus1.in_data = 160'h22;
        step(1);
        check_eq("fl_pre_occ", bus1.occupancy, 2);
        flush = 1'b1;
        bus0.in_valid = 1'b1; bus0.in_data = 160'hDEAD; bus0.in_ctrl = 1'b1;
        bus1.in_data = 160'hBEEF;
        step(1);
        flush = 1'b0;
        idle_inputs();
        check_eq("fl_ov1",  bus1.out_valid, 0);
        check_eq("fl_oc1",  bus1.out_ctrl, 0);
        check_eq("fl_occ1", bus1.occupancy, 0);
        check_eq("fl_ir1",  bus1.in_ready, 1);
        check_eq("fl_ov0",  bus0.out_valid, 0);
        check_eq("fl_oc0",  bus0.out_ctrl, 0);
        check_eq("fl_occ0", bus0.occupancy, 0);
        bus1.out_ready = 1'b1;
        step(4);
        check_eq("fl_post_ov1", bus1.out_valid, 0);
        check_eq("fl_post_ov0", bus0.out_valid, 0);

        // Reset with a full skid stage and flush asserted together
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 160'h31; bus1.in_ctrl = 1'b1;
        step(1);
        bus1.in_data = 160'h32;
        step(1);
        check_eq("rm_pre_occ", bus1.occupancy, 2);
        reset = 1'b1;
        flush = 1'b1;
        bus0.in_valid = 1'b1; bus0.in_data = 160'h77; bus0.in_ctrl = 1'b1;
        step(2);
        check_reset_state();
        reset = 1'b0;
        flush = 1'b0;
        idle_inputs();
        #1;
        check_eq("rm_ir0", bus0.in_ready, 1);
        check_eq("rm_ir1", bus1.in_ready, 1);
        bus1.out_ready = 1'b1;
        step(3);
        check_eq("rm_post_ov1", bus1.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
